// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the data-RAM port arbiter.
// Read ownership is recorded per cycle so that returning data reaches the right requester.
package dm_arb_pkg;

  localparam int         DATA_W_DEF   = 32;
  localparam int         BE_W         = DATA_W_DEF / 8;
  localparam int         MAX_WAIT_DEF = 4;
  localparam logic [3:0] WAIT_SAT     = 4'd15;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

endpackage

// File: rtl/dm_req_mux.sv
// Selects the address, write data and byte write enables of the granted requester.
// With no grant, every output is zero so the RAM pins stay quiet.
module dm_req_mux #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                  sel_cpu,
  input  logic                  sel_dbg,
  input  logic                  cpu_we,
  input  logic [DATA_W/8-1:0]   cpu_be,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic                  dbg_we,
  input  logic [DATA_W/8-1:0]   dbg_be,
  input  logic [ADDR_W-1:0]     dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic [ADDR_W-1:0]     addr,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wea
);

  localparam int NB = DATA_W / 8;

  // Granted-side field selection.
  always_comb begin
    addr  = {ADDR_W{1'b0}};
    wdata = {DATA_W{1'b0}};
    wea   = {NB{1'b0}};
    case ({sel_cpu, sel_dbg})
      2'b10: begin
        addr  = cpu_addr;
        wdata = cpu_wdata;
        wea   = cpu_be & {NB{cpu_we}};
      end
      2'b01: begin
        addr  = dbg_addr;
        wdata = dbg_wdata;
        wea   = dbg_be & {NB{dbg_we}};
      end
      default: begin
        addr  = {ADDR_W{1'b0}};
        wdata = {DATA_W{1'b0}};
        wea   = {NB{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single-port data RAM between the CPU Access stage (fixed priority) and a
// debug/loader port, with a starvation counter that eventually forces one DBG slot.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [DATA_W/8-1:0]   cpu_be,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [DATA_W-1:0]     cpu_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [DATA_W/8-1:0]   dbg_be,
  input  logic [ADDR_W-1:0]     dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  ram_ena,
  output logic [DATA_W/8-1:0]   ram_wea,
  output logic [ADDR_W-1:0]     ram_addra,
  output logic [DATA_W-1:0]     ram_dina,
  input  logic [DATA_W-1:0]     ram_douta
);

  localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_r;
  logic [3:0] wait_cnt_nxt_s;
  owner_e     rd_owner_r;
  owner_e     rd_owner_nxt_s;
  logic       force_dbg_s;
  logic       grant_dbg_s;
  logic       grant_cpu_s;

  // Grants are qualified by rstn so the RAM and handshakes stay idle while in reset.
  assign force_dbg_s = (wait_cnt_r >= MAX_WAIT_L);
  assign grant_dbg_s = rstn & dbg_req & (force_dbg_s | ~cpu_req);
  assign grant_cpu_s = rstn & cpu_req & ~grant_dbg_s;

  assign cpu_stall = rstn & cpu_req & ~grant_cpu_s;
  assign dbg_gnt   = grant_dbg_s;
  assign ram_ena   = grant_cpu_s | grant_dbg_s;

  dm_req_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_req_mux (
    .sel_cpu   (grant_cpu_s),
    .sel_dbg   (grant_dbg_s),
    .cpu_we    (cpu_we),
    .cpu_be    (cpu_be),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .dbg_we    (dbg_we),
    .dbg_be    (dbg_be),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .addr      (ram_addra),
    .wdata     (ram_dina),
    .wea       (ram_wea)
  );

  // Starvation counter: counts consecutive denied DBG cycles, saturating.
  always_comb begin
    wait_cnt_nxt_s = wait_cnt_r;
    if (!dbg_req || grant_dbg_s) begin
      wait_cnt_nxt_s = 4'd0;
    end else if (wait_cnt_r == WAIT_SAT) begin
      wait_cnt_nxt_s = WAIT_SAT;
    end else begin
      wait_cnt_nxt_s = wait_cnt_r + 4'd1;
    end
  end

  // Owner of the read whose data the RAM presents next cycle.
  always_comb begin
    rd_owner_nxt_s = OWN_NONE;
    if (grant_cpu_s && !cpu_we) begin
      rd_owner_nxt_s = OWN_CPU;
    end else if (grant_dbg_s && !dbg_we) begin
      rd_owner_nxt_s = OWN_DBG;
    end else begin
      rd_owner_nxt_s = OWN_NONE;
    end
  end

  // State registers; reset drops any pending read return.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt_r <= 4'd0;
      rd_owner_r <= OWN_NONE;
    end else begin
      wait_cnt_r <= wait_cnt_nxt_s;
      rd_owner_r <= rd_owner_nxt_s;
    end
  end

  assign cpu_rvalid = (rd_owner_r == OWN_CPU);
  assign dbg_rvalid = (rd_owner_r == OWN_DBG);
  assign cpu_rdata  = cpu_rvalid ? ram_douta : {DATA_W{1'b0}};
  assign dbg_rdata  = dbg_rvalid ? ram_douta : {DATA_W{1'b0}};

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural write-first RAM and a read-return scoreboard.
module tb_dm_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [BW-1:0] cpu_be, dbg_be;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata;
  logic          cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, ram_ena;
  logic [DW-1:0] cpu_rdata, dbg_rdata, ram_dina, ram_douta;
  logic [BW-1:0] ram_wea;
  logic [AW-1:0] ram_addra;

  always #5 clk = ~clk;

  dm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_be(dbg_be), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_douta(ram_douta)
  );

  // Single-port RAM, 1-cycle registered read, write-first.
  logic [DW-1:0] mem [0:4095];
  always @(posedge clk) begin : ram_model
    logic [DW-1:0] w;
    if (ram_ena) begin
      w = mem[ram_addra];
      for (int b = 0; b < BW; b++) begin
        if (ram_wea[b]) w[8*b +: 8] = ram_dina[8*b +: 8];
      end
      mem[ram_addra] <= w;
      ram_douta      <= w;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_cpu [$];
  logic [DW-1:0] exp_dbg [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every read return is matched against the requester's queue.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (cpu_rvalid) begin
        if (exp_cpu.size() == 0) chk("cpu_rvalid_unexpected", {31'd0, cpu_rvalid}, 32'd0);
        else chk("cpu_rdata", cpu_rdata, exp_cpu.pop_front());
      end
      if (dbg_rvalid) begin
        if (exp_dbg.size() == 0) chk("dbg_rvalid_unexpected", {31'd0, dbg_rvalid}, 32'd0);
        else chk("dbg_rdata", dbg_rdata, exp_dbg.pop_front());
      end
    end
  end

  task automatic drive(input logic cr, input logic cw, input logic [3:0] cbe,
                       input logic [11:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic [3:0] dbe,
                       input logic [11:0] da, input logic [31:0] dd);
    @(negedge clk);
    cpu_req = cr; cpu_we = cw; cpu_be = cbe; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_be = dbe; dbg_addr = da; dbg_wdata = dd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, 12'h000, 32'h0, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
  endtask

  initial begin
    mem[12'h001] = 32'h01010101; mem[12'h002] = 32'h02020202; mem[12'h003] = 32'h03030303;
    mem[12'h010] = 32'hDEADBEEF; mem[12'h020] = 32'h11223344; mem[12'h030] = 32'h30303030;
    mem[12'h031] = 32'h31313131; mem[12'h040] = 32'h40404040; mem[12'h050] = 32'h50505050;

    // Reset with both requesters active: everything must stay quiet.
    rstn = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF; cpu_addr = 12'h010; cpu_wdata = 32'h0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_be = 4'hF; dbg_addr = 12'h030; dbg_wdata = 32'h0;
    #2;
    chk("rst_ram_ena",    {31'd0, ram_ena},    32'd0);
    chk("rst_ram_wea",    {28'd0, ram_wea},    32'd0);
    chk("rst_cpu_stall",  {31'd0, cpu_stall},  32'd0);
    chk("rst_dbg_gnt",    {31'd0, dbg_gnt},    32'd0);
    chk("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("rst_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    idle();
    @(negedge clk); rstn = 1'b1;

    // CPU-only read.
    drive(1'b1, 1'b0, 4'hF, 12'h010, 32'h0, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
    chk("cpu_rd_ram_ena",   {31'd0, ram_ena},   32'd1);
    chk("cpu_rd_stall",     {31'd0, cpu_stall}, 32'd0);
    chk("cpu_rd_ram_addra", {20'd0, ram_addra}, 32'h010);
    chk("cpu_rd_ram_wea",   {28'd0, ram_wea},   32'd0);
    exp_cpu.push_back(32'hDEADBEEF);

    // CPU byte write then read-back.
    drive(1'b1, 1'b1, 4'b0100, 12'h020, 32'h00AB0000, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
    chk("cpu_wr_ram_wea",  {28'd0, ram_wea}, 32'h4);
    chk("cpu_wr_ram_dina", ram_dina,         32'h00AB0000);
    chk("cpu_wr_stall",    {31'd0, cpu_stall}, 32'd0);
    drive(1'b1, 1'b0, 4'hF, 12'h020, 32'h0, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
    exp_cpu.push_back(32'h11AB3344);

    // Contention: DBG denied MAX_WAIT cycles, then forced ahead of the CPU.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 4'hF, 12'h040, 32'h0, 1'b1, 1'b0, 4'hF, 12'h030, 32'h0);
      chk("cont_dbg_gnt",   {31'd0, dbg_gnt},   32'd0);
      chk("cont_cpu_stall", {31'd0, cpu_stall}, 32'd0);
      chk("cont_wait_cnt",  {28'd0, dut.wait_cnt_r}, 32'(i));
      exp_cpu.push_back(32'h40404040);
    end
    drive(1'b1, 1'b0, 4'hF, 12'h040, 32'h0, 1'b1, 1'b0, 4'hF, 12'h030, 32'h0);
    chk("force_dbg_gnt",   {31'd0, dbg_gnt},   32'd1);
    chk("force_cpu_stall", {31'd0, cpu_stall}, 32'd1);
    chk("force_ram_addra", {20'd0, ram_addra}, 32'h030);
    exp_dbg.push_back(32'h30303030);
    // A fresh DBG request right after its slot starts counting from zero again.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 4'hF, 12'h040, 32'h0, 1'b1, 1'b0, 4'hF, 12'h031, 32'h0);
      chk("cont2_dbg_gnt",   {31'd0, dbg_gnt},   32'd0);
      chk("cont2_cpu_stall", {31'd0, cpu_stall}, 32'd0);
      chk("cont2_wait_cnt",  {28'd0, dut.wait_cnt_r}, 32'(i));
      exp_cpu.push_back(32'h40404040);
    end
    drive(1'b1, 1'b0, 4'hF, 12'h040, 32'h0, 1'b1, 1'b0, 4'hF, 12'h031, 32'h0);
    chk("force2_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
    exp_dbg.push_back(32'h31313131);

    // Idle CPU: DBG granted immediately; partial write then read-back.
    drive(1'b0, 1'b0, 4'h0, 12'h000, 32'h0, 1'b1, 1'b0, 4'hF, 12'h050, 32'h0);
    chk("idle_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
    chk("idle_ram_ena", {31'd0, ram_ena}, 32'd1);
    exp_dbg.push_back(32'h50505050);
    drive(1'b0, 1'b0, 4'h0, 12'h000, 32'h0, 1'b1, 1'b1, 4'b0011, 12'h050, 32'h0000BEEF);
    chk("idle_dbg_wr_gnt", {31'd0, dbg_gnt}, 32'd1);
    chk("idle_dbg_wr_wea", {28'd0, ram_wea}, 32'h3);
    drive(1'b0, 1'b0, 4'h0, 12'h000, 32'h0, 1'b1, 1'b0, 4'hF, 12'h050, 32'h0);
    exp_dbg.push_back(32'h5050BEEF);

    // Interleave CPU / DBG / CPU reads in consecutive cycles.
    drive(1'b1, 1'b0, 4'hF, 12'h001, 32'h0, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
    exp_cpu.push_back(32'h01010101);
    drive(1'b0, 1'b0, 4'h0, 12'h000, 32'h0, 1'b1, 1'b0, 4'hF, 12'h002, 32'h0);
    chk("ilv_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
    exp_dbg.push_back(32'h02020202);
    drive(1'b1, 1'b0, 4'hF, 12'h003, 32'h0, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
    exp_cpu.push_back(32'h03030303);
    idle();
    idle();

    // Reset during the return cycle of a granted read: the return is discarded.
    drive(1'b1, 1'b0, 4'hF, 12'h010, 32'h0, 1'b1, 1'b0, 4'hF, 12'h030, 32'h0);
    @(posedge clk); #1;
    chk("pre_rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    chk("pre_rst_wait_cnt",   {28'd0, dut.wait_cnt_r}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("mid_rst_ram_ena",    {31'd0, ram_ena},    32'd0);
    chk("mid_rst_wait_cnt",   {28'd0, dut.wait_cnt_r}, 32'd0);
    chk("mid_rst_dbg_gnt",    {31'd0, dbg_gnt},    32'd0);
    idle();
    @(negedge clk); rstn = 1'b1;
    drive(1'b1, 1'b0, 4'hF, 12'h010, 32'h0, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0);
    chk("post_rst_ram_ena", {31'd0, ram_ena},   32'd1);
    chk("post_rst_stall",   {31'd0, cpu_stall}, 32'd0);
    exp_cpu.push_back(32'hDEADBEEF);
    idle();
    idle();

    chk("cpu_queue_drained", 32'(exp_cpu.size()), 32'd0);
    chk("dbg_queue_drained", 32'(exp_dbg.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
